// File: rtl/jzjpcc_arb_pkg.sv
// Shared types and widths for the JZJPCC memory arbiter: read-owner tags and arbitration states.
package jzjpcc_arb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_CORE,
    OWNER_EXT
  } owner_t;

  typedef enum logic [1:0] {
    CORE_PRI,
    EXT_PRI,
    EXT_LOCKED
  } arb_state_t;

endpackage

// File: rtl/jzjpcc_starve_counter.sv
// Saturating count of consecutive cycles the ext requester was refused.
module jzjpcc_starve_counter
  import jzjpcc_arb_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  input  logic [STARVE_W-1:0] limit,
  output logic [STARVE_W-1:0] count,
  output logic                atLimit
);

  // Clear wins over increment; the count never passes the limit.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count < limit)) begin
      count <= count + STARVE_W'(1);
    end
  end

  assign atLimit = (count == limit);

endmodule

// File: rtl/jzjpcc_mem_arbiter.sv
// Two-requester (core / ext loader) arbiter in front of a single-port RAM with
// one-cycle read latency; ext gets priority after starvation or while it holds a lock.
module jzjpcc_mem_arbiter
  import jzjpcc_arb_pkg::*;
#(
  parameter int unsigned RAM_A_WIDTH  = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   coreReq,
  input  logic                   coreWriteEnable,
  input  logic [RAM_A_WIDTH-1:0] coreAddr,
  input  logic [DATA_W-1:0]      coreWriteData,
  input  logic [BE_W-1:0]        coreByteEnable,
  output logic                   coreReady,
  output logic                   coreReadValid,
  output logic [DATA_W-1:0]      coreReadData,
  output logic                   coreStall,

  input  logic                   extReq,
  input  logic                   extWriteEnable,
  input  logic [RAM_A_WIDTH-1:0] extAddr,
  input  logic [DATA_W-1:0]      extWriteData,
  input  logic [BE_W-1:0]        extByteEnable,
  input  logic                   extLock,
  output logic                   extReady,
  output logic                   extReadValid,
  output logic [DATA_W-1:0]      extReadData,

  output logic [RAM_A_WIDTH-1:0] ramAddr,
  output logic [DATA_W-1:0]      ramWriteData,
  output logic [BE_W-1:0]        ramByteEnable,
  output logic                   ramWriteEnable,
  input  logic [DATA_W-1:0]      ramReadData
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);

  arb_state_t             state;
  owner_t                 owner;
  logic                   reset_q;
  logic [RAM_A_WIDTH-1:0] ram_addr_q;
  logic [DATA_W-1:0]      ram_wdata_q;

  logic                   block;
  logic                   grant_core;
  logic                   grant_ext;
  logic                   starve_inc;
  logic                   starve_clr;
  logic                   starve_hit;
  logic                   starve_at_limit;
  logic [STARVE_W-1:0]    starve_count;

  // No grants while reset is applied nor in the first cycle after it.
  assign block = reset || reset_q;

  always_comb begin
    grant_core = 1'b0;
    grant_ext  = 1'b0;
    if (!block) begin
      case (state)
        CORE_PRI: begin
          grant_core = coreReq;
          grant_ext  = extReq && !coreReq;
        end
        EXT_PRI: begin
          grant_ext  = extReq;
          grant_core = coreReq && !extReq;
        end
        EXT_LOCKED: begin
          grant_ext  = extReq;
        end
        default: begin
          grant_core = 1'b0;
          grant_ext  = 1'b0;
        end
      endcase
    end
  end

  assign coreReady = grant_core;
  assign extReady  = grant_ext;
  assign coreStall = coreReq && !grant_core;

  assign starve_inc = extReq && !grant_ext && !block;
  assign starve_clr = !extReq || grant_ext || block;
  // Priority flips on the same edge the count reaches its limit.
  assign starve_hit = starve_inc &&
                      (starve_at_limit || ((starve_count + STARVE_W'(1)) == STARVE_LIM));

  jzjpcc_starve_counter u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .limit   (STARVE_LIM),
    .count   (starve_count),
    .atLimit (starve_at_limit)
  );

  assign ramAddr        = grant_core ? coreAddr : (grant_ext ? extAddr : ram_addr_q);
  assign ramWriteData   = grant_core ? coreWriteData : (grant_ext ? extWriteData : ram_wdata_q);
  assign ramByteEnable  = grant_core ? coreByteEnable : (grant_ext ? extByteEnable : '0);
  assign ramWriteEnable = (grant_core && coreWriteEnable) || (grant_ext && extWriteEnable);

  // Read return is steered to the registered owner; masked while reset is applied.
  assign coreReadValid = (owner == OWNER_CORE) && !reset;
  assign extReadValid  = (owner == OWNER_EXT) && !reset;
  assign coreReadData  = coreReadValid ? ramReadData : '0;
  assign extReadData   = extReadValid ? ramReadData : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CORE_PRI;
      owner       <= OWNER_NONE;
      reset_q     <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      reset_q     <= 1'b0;
      ram_addr_q  <= ramAddr;
      ram_wdata_q <= ramWriteData;

      if (grant_core && !coreWriteEnable) begin
        owner <= OWNER_CORE;
      end else if (grant_ext && !extWriteEnable) begin
        owner <= OWNER_EXT;
      end else begin
        owner <= OWNER_NONE;
      end

      case (state)
        CORE_PRI: begin
          if (grant_ext && extLock) begin
            state <= EXT_LOCKED;
          end else if (starve_hit) begin
            state <= EXT_PRI;
          end
        end
        EXT_PRI: begin
          if (grant_ext && extLock) begin
            state <= EXT_LOCKED;
          end else if (grant_ext || !extReq) begin
            state <= CORE_PRI;
          end
        end
        EXT_LOCKED: begin
          if ((grant_ext && !extLock) || !extReq) begin
            state <= CORE_PRI;
          end
        end
        default: state <= CORE_PRI;
      endcase
    end
  end

endmodule

// File: doc/jzjpcc_mem_arbiter.md
JZJPCC_MEM_ARBITER -- requirements
Module: jzjpcc_mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_A_WIDTH, default 12: RAM word-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles extReq may be refused before it takes priority; legal range 1..15.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clock, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have core port group, from the memory stage:
- coreReq, in, 1
- coreWriteEnable, in, 1
- coreAddr, in, RAM_A_WIDTH
- coreWriteData, in, 32
- coreByteEnable, in, 4
- coreReady, out, 1: accept this cycle
- coreReadValid, out, 1
- coreReadData, out, 32
- coreStall, out, 1: to hazard unit
REQ-007 SHALL have ext port group (debug/DMA loader), same meanings: extReq, extWriteEnable, extAddr, extWriteData, extByteEnable, extLock (in, 1: hold grant for burst), extReady, extReadValid, extReadData.
REQ-008 SHALL have RAM port group:
- ramAddr, out, RAM_A_WIDTH
- ramWriteData, out, 32
- ramByteEnable, out, 4
- ramWriteEnable, out, 1
- ramReadData, in, 32: valid one cycle after address

Function
REQ-009 SHALL accept a transfer when xReq && xReady in the same cycle; requester holds its request fields stable until accepted.
REQ-010 SHALL grant at most one requester per cycle; coreReady/extReady are combinational from requests, FSM state and starvation counter.
REQ-011 SHALL drive ram* from the granted requester in the accept cycle; with no grant, ramWriteEnable=0, ramByteEnable=0 and ramAddr/ramWriteData hold their previous values.
REQ-012 SHALL register the owner of each accepted read; one cycle later the owner's ReadValid=1 and its ReadData=ramReadData; the other requester's ReadData=0.
REQ-013 SHALL assert no ReadValid for a write.
REQ-014 SHALL support back-to-back accepts from either requester: throughput 1 per cycle, read latency 1.
REQ-015 SHALL implement FSM states CORE_PRI, EXT_PRI and EXT_LOCKED:
- CORE_PRI: core wins if coreReq; otherwise ext wins.
- EXT_PRI: ext wins if extReq.
- EXT_LOCKED: only ext may be granted; coreReady=0.
REQ-016 SHALL transition CORE_PRI -> EXT_PRI when starveCount == STARVE_LIMIT.
REQ-017 SHALL transition EXT_PRI -> CORE_PRI after one ext accept with extLock=0, or when extReq=0.
REQ-018 SHALL transition any state -> EXT_LOCKED on an ext accept with extLock=1.
REQ-019 SHALL transition EXT_LOCKED -> CORE_PRI on an ext accept with extLock=0, or on any cycle with extReq=0.
REQ-020 SHALL maintain starveCount (4 bits):
- increments each cycle extReq=1 && extReady=0, saturating at STARVE_LIMIT;
- clears on ext accept or extReq=0;
- has priority over the transition in REQ-016 only after the increment.
REQ-021 SHALL drive coreStall = coreReq && !coreReady.
REQ-022 SHALL, when both requesters issue the same address in consecutive cycles, complete them in grant order with no forwarding; a read after a write observes the written data.

Reset
REQ-023 SHALL, on reset, set state=CORE_PRI, starveCount=0 and read owner=none.
REQ-024 SHALL, during and in the cycle after reset, drive ReadValid=0, ReadData=0 and ramWriteEnable=0; in-flight reads are discarded with no ReadValid.
REQ-025 SHALL drive ramAddr=0 and ramWriteData=0 from reset until the first grant.

Structure
REQ-026 SHALL place owner_t {OWNER_NONE, OWNER_CORE, OWNER_EXT} and arb_state_t {CORE_PRI, EXT_PRI, EXT_LOCKED} in shared package jzjpcc_arb_pkg.
REQ-027 SHALL implement the saturating starvation counter as sub-module jzjpcc_starve_counter (inputs: inc, clr, limit; outputs: count, atLimit).
REQ-028 SHALL contain no latches, one always_ff for state/owner, and combinational grant logic.

Verification
REQ-029 SHALL cover core-only traffic: core writes 0xDEADBEEF to 0x010 then reads 0x010 back-to-back -> coreReady=1 both cycles; coreReadValid=1 with 0xDEADBEEF one cycle after the read accept; coreStall never asserted.
REQ-030 SHALL cover starvation with STARVE_LIMIT=4: coreReq and extReq held high continuously -> ext accepted on the 5th cycle, then core resumes; pattern repeats every 5 cycles.
REQ-031 SHALL cover ext lock: ext issues 3 writes, extLock=1 on the first two -> core stalled for all 3 cycles; coreReady returns 1 the cycle after the extLock=0 accept.
REQ-032 SHALL cover simultaneous reads: core reads 0x004 and ext reads 0x008 in the same cycle in CORE_PRI -> core granted; ext granted next cycle; each ReadValid reaches only its owner with the correct data.
REQ-033 SHALL cover reset mid-read: reset asserted in the cycle after a core read accept -> coreReadValid=0, FSM=CORE_PRI, starveCount=0 after reset.
REQ-034 SHALL cover ext request withdrawal: extReq dropped after 3 refused cycles -> starveCount returns to 0 and no EXT_PRI entry.
